// File: rtl/cnv_out_wr_packer.sv
// Output-line writer: buffers wide post-processed words and serialises them into
// addressed AXI write beats, dropping pixels past the output width.
module cnv_out_wr_packer #(
    parameter int AXIWIDTH   = 128,
    parameter int DWIDTH     = 8,
    parameter int CH_OUT     = 32,
    parameter int PIX        = 8,
    parameter int LITEWIDTH  = 32,
    parameter int DEPTHWIDTH = 9,
    parameter int W_WIDTH    = 10
) (
    input  logic                         I_clk,
    input  logic                         I_rst,
    input  logic                         I_ap_start,
    input  logic [LITEWIDTH-1:0]         I_img_out_addr,
    input  logic [W_WIDTH-1:0]           I_owidth,
    input  logic [W_WIDTH-1:0]           I_oheight,
    input  logic [DEPTHWIDTH-1:0]        I_co_beats,
    input  logic [DEPTHWIDTH-1:0]        I_coGroup,
    input  logic [DEPTHWIDTH-1:0]        I_woGroup,
    input  logic [DWIDTH*CH_OUT*PIX-1:0] I_data,
    input  logic                         I_data_dv,
    output logic                         O_data_rdy,
    output logic [AXIWIDTH-1:0]          O_wr_data,
    output logic                         O_wr_dv,
    input  logic                         I_wr_rdy,
    output logic [LITEWIDTH-1:0]         O_wr_addr,
    output logic                         O_line_done,
    output logic                         O_layer_done,
    output logic                         O_busy,
    output logic [1:0]                   O_dbg_state
);
    localparam int LANES = AXIWIDTH / DWIDTH;
    localparam int CB    = CH_OUT / LANES;
    localparam int BYTES = AXIWIDTH / 8;
    localparam int IN_W  = DWIDTH * CH_OUT * PIX;
    localparam int CW    = (CB > 1) ? $clog2(CB) : 1;
    localparam int PW    = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int SW    = $clog2(IN_W);
    localparam int IW    = W_WIDTH + DEPTHWIDTH + PW;
    localparam int MW    = W_WIDTH + DEPTHWIDTH;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
    state_t state, state_nx;

    logic [IN_W-1:0]       buf_mem [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic [W_WIDTH-1:0]    owidth_q, oheight_q, h;
    logic [DEPTHWIDTH-1:0] co_beats_q, cog_grp_q, wo_grp_q, cog, wo;
    logic [PW-1:0]         p;
    logic [CW-1:0]         c;
    logic [IW-1:0]         wo_pix;
    logic [LITEWIDTH-1:0]  line_base, line_stride, wo_addr, pix_addr, cog_off;
    logic [MW-1:0]         stride_px;
    logic                  out_last, out_final, line_done_q, final_q;

    logic                  full, empty, push, active, accept, can_load;
    logic                  pix_ok, last_c, last_pix, skip, issue, rel, line_end_entry, last_line;
    logic [IW-1:0]         pix_idx;
    logic [LITEWIDTH-1:0]  px_bytes, wo_step, beat_addr;
    logic [SW-1:0]         sel;
    logic [IN_W-1:0]       head;

    // Both ports use the same handshake: a transfer happens on a rising edge where
    // valid and ready are both high; valid never depends on ready.
    assign full       = (count == 2'd2);
    assign empty      = (count == 2'd0);
    assign O_data_rdy = (state == S_RUN) && !full;
    assign push       = I_data_dv && O_data_rdy;
    assign head       = buf_mem[rd_ptr];

    assign pix_idx  = wo_pix + IW'(p);
    assign pix_ok   = pix_idx < IW'(owidth_q);
    assign last_c   = (c == CW'(CB - 1));
    assign last_pix = (p == PW'(PIX - 1)) || ((pix_idx + 1'b1) >= IW'(owidth_q));
    assign active   = (state == S_RUN) && !empty && (h < oheight_q);
    assign accept   = O_wr_dv && I_wr_rdy;
    assign can_load = !O_wr_dv || I_wr_rdy;
    assign skip     = active && !pix_ok;
    assign issue    = active && pix_ok && can_load;
    assign rel      = skip || (issue && last_c && last_pix);

    assign line_end_entry = (wo == wo_grp_q - 1'b1) && (cog == cog_grp_q - 1'b1);
    assign last_line      = (h == oheight_q - 1'b1);

    assign sel       = SW'((int'(p) * CH_OUT + int'(c) * LANES) * DWIDTH);
    assign px_bytes  = LITEWIDTH'(co_beats_q) * LITEWIDTH'(BYTES);
    assign wo_step   = px_bytes * LITEWIDTH'(PIX);
    assign beat_addr = pix_addr + cog_off + LITEWIDTH'(c) * LITEWIDTH'(BYTES);

    assign O_busy       = (state != S_IDLE);
    assign O_layer_done = (state == S_DONE);
    assign O_line_done  = line_done_q;
    assign O_dbg_state  = state;

    always_ff @(posedge I_clk) begin
        if (I_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (I_ap_start) begin
            state_nx = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (final_q) state_nx = S_DONE;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (push) buf_mem[wr_ptr] <= I_data;
    end

    // Stride is only needed at the first line end, so a two-stage multiply is safe.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            stride_px   <= '0;
            line_stride <= '0;
        end else begin
            stride_px   <= MW'(owidth_q) * MW'(co_beats_q);
            line_stride <= LITEWIDTH'(stride_px) * LITEWIDTH'(BYTES);
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            owidth_q <= '0; oheight_q <= '0; co_beats_q <= '0; cog_grp_q <= '0; wo_grp_q <= '0;
            line_base <= '0; wo_addr <= '0; pix_addr <= '0; cog_off <= '0;
            cog <= '0; wo <= '0; p <= '0; c <= '0; h <= '0; wo_pix <= '0;
            count <= '0; wr_ptr <= 1'b0; rd_ptr <= 1'b0;
            O_wr_dv <= 1'b0; O_wr_data <= '0; O_wr_addr <= '0;
            out_last <= 1'b0; out_final <= 1'b0; line_done_q <= 1'b0; final_q <= 1'b0;
        end else if (I_ap_start) begin
            owidth_q <= I_owidth; oheight_q <= I_oheight; co_beats_q <= I_co_beats;
            cog_grp_q <= I_coGroup; wo_grp_q <= I_woGroup;
            line_base <= I_img_out_addr; wo_addr <= I_img_out_addr; pix_addr <= I_img_out_addr;
            cog_off <= '0;
            cog <= '0; wo <= '0; p <= '0; c <= '0; h <= '0; wo_pix <= '0;
            count <= '0; wr_ptr <= 1'b0; rd_ptr <= 1'b0;
            O_wr_dv <= 1'b0; out_last <= 1'b0; out_final <= 1'b0;
            line_done_q <= 1'b0; final_q <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            final_q     <= 1'b0;
            if (push) wr_ptr <= ~wr_ptr;
            if (rel)  rd_ptr <= ~rd_ptr;
            if (push && !rel)      count <= count + 2'd1;
            else if (!push && rel) count <= count - 2'd1;

            if (accept) begin
                O_wr_dv <= 1'b0;
                if (out_last) begin
                    line_done_q <= 1'b1;
                    final_q     <= out_final;
                end
            end

            if (issue) begin
                O_wr_dv   <= 1'b1;
                O_wr_data <= head[sel +: AXIWIDTH];
                O_wr_addr <= beat_addr;
                out_last  <= rel && line_end_entry;
                out_final <= last_line;
                if (!last_c) begin
                    c <= c + 1'b1;
                end else begin
                    c <= '0;
                    if (!last_pix) begin
                        p        <= p + 1'b1;
                        pix_addr <= pix_addr + px_bytes;
                    end
                end
            end

            // An empty closing entry moves the line end onto the beat still held, if any.
            if (skip && line_end_entry) begin
                if (O_wr_dv && !I_wr_rdy) begin
                    out_last  <= 1'b1;
                    out_final <= last_line;
                end else begin
                    line_done_q <= 1'b1;
                    final_q     <= last_line;
                end
            end

            if (rel) begin
                p <= '0;
                c <= '0;
                if (wo == wo_grp_q - 1'b1) begin
                    wo     <= '0;
                    wo_pix <= '0;
                    if (cog == cog_grp_q - 1'b1) begin
                        cog       <= '0;
                        cog_off   <= '0;
                        h         <= h + 1'b1;
                        line_base <= line_base + line_stride;
                        wo_addr   <= line_base + line_stride;
                        pix_addr  <= line_base + line_stride;
                    end else begin
                        cog      <= cog + 1'b1;
                        cog_off  <= cog_off + LITEWIDTH'(CB * BYTES);
                        wo_addr  <= line_base;
                        pix_addr <= line_base;
                    end
                end else begin
                    wo       <= wo + 1'b1;
                    wo_pix   <= wo_pix + IW'(PIX);
                    wo_addr  <= wo_addr + wo_step;
                    pix_addr <= wo_addr + wo_step;
                end
            end
        end
    end
endmodule
